// File: rtl/vm_pkg.sv
// Shared definitions for the vending-machine front end: coin codes and the
// debounce FSM state type.
package vm_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_ONE  = 2'b01;
  localparam logic [1:0] COIN_TWO  = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StArming,
    StLatched,
    StReleasing
  } deb_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin sensor: 2-flop synchronizer followed by a debounce FSM that emits a
// single-cycle `qualify` pulse when a stable high level has been accepted.
module coin_debounce
  import vm_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic qualify
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [1:0]      sync_q;
  logic            sync;
  deb_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            qualify_q, qualify_d;

  // Two-stage synchronizer for the asynchronous sensor line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  assign sync = sync_q[1];

  // State, counter and qualify registers; reset into RELEASING so a coin held
  // across reset must first be seen low before it can count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StReleasing;
      cnt_q     <= '0;
      qualify_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      qualify_q <= qualify_d;
    end
  end

  // Next-state logic: a level change is accepted only after the counter has
  // reached DEB_CYCLES with the synchronized line still at the new level.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    qualify_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sync) begin
          state_d = StArming;
          cnt_d   = CntOne;
        end
      end
      StArming: begin
        if (!sync) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d   = StLatched;
          cnt_d     = '0;
          qualify_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StLatched: begin
        if (!sync) begin
          state_d = StReleasing;
          cnt_d   = CntOne;
        end
      end
      StReleasing: begin
        if (sync) begin
          state_d = StLatched;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StReleasing;
        cnt_d   = '0;
      end
    endcase
  end

  assign qualify = qualify_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: two debounced sensors feed a small coin FIFO that drains into
// ven_machine one code per cycle while `hold` is low. Colliding or
// unqueueable coins pulse `reject`.
// Optional build macro COIN_COUNT_EN adds per-type popped-coin totals
// (cnt1/cnt2, saturating).
module coin_acceptor
  import vm_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        coin1_raw,
  input  logic        coin2_raw,
  input  logic        hold,
  output logic [1:0]  coin_out,
  output logic        reject,
  output logic        fifo_full,
`ifdef COIN_COUNT_EN
  output logic        fifo_empty,
  output logic [15:0] cnt1,
  output logic [15:0] cnt2
`else
  output logic        fifo_empty
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);

  logic            qual1, qual2;
  logic            one_qual, push, pop;
  logic [1:0]      push_code;
  logic [1:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, full_d, empty_q, empty_d;
  logic [1:0]      coin_out_q, coin_out_d;
  logic            reject_q, reject_d;

  coin_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb1 (
    .clk    (clk),
    .rst    (rst),
    .raw    (coin1_raw),
    .qualify(qual1)
  );

  coin_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb2 (
    .clk    (clk),
    .rst    (rst),
    .raw    (coin2_raw),
    .qualify(qual2)
  );

  // Pop uses registered status only; a pop frees a slot for a same-cycle push.
  assign pop       = !empty_q && !hold;
  assign one_qual  = qual1 ^ qual2;
  assign push      = one_qual && (!full_q || pop);
  assign push_code = qual1 ? COIN_ONE : COIN_TWO;

  // Next-state for pointers, occupancy, status flags and the output codes.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    coin_out_d = COIN_NONE;
    reject_d   = (qual1 && qual2) || (one_qual && full_q && !pop);
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PtrOne;
      coin_out_d = mem_q[rd_ptr_q];
    end
    if (push && !pop) begin
      count_d = count_q + CntOne;
    end else if (!push && pop) begin
      count_d = count_q - CntOne;
    end
    full_d  = (count_d == DepthCnt);
    empty_d = (count_d == '0);
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      coin_out_q <= COIN_NONE;
      reject_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      coin_out_q <= coin_out_d;
      reject_q   <= reject_d;
    end
  end

  // Queue storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_code;
    end
  end

  assign coin_out   = coin_out_q;
  assign reject     = reject_q;
  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;

`ifdef COIN_COUNT_EN
  logic [15:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;

  // Totals advance on the pop that delivers the coin to ven_machine.
  always_comb begin
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    if (pop && (mem_q[rd_ptr_q] == COIN_ONE)) begin
      cnt1_d = sat_inc16(cnt1_q);
    end
    if (pop && (mem_q[rd_ptr_q] == COIN_TWO)) begin
      cnt2_d = sat_inc16(cnt2_q);
    end
  end

  // Coin total registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else begin
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
    end
  end

  assign cnt1 = cnt1_q;
  assign cnt2 = cnt2_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed corner sequences, a scenario table and a
// randomized phase, all checked cycle by cycle against a run-length/queue
// reference model.
module tb_coin_acceptor;
  import vm_pkg::*;

  localparam int unsigned Deb   = 4;
  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        coin1_raw, coin2_raw, hold;
  logic [1:0]  coin_out;
  logic        reject, fifo_full, fifo_empty;
`ifdef COIN_COUNT_EN
  logic [15:0] cnt1, cnt2;
`endif

  coin_acceptor #(
    .DEB_CYCLES(Deb),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .coin1_raw (coin1_raw),
    .coin2_raw (coin2_raw),
    .hold      (hold),
    .coin_out  (coin_out),
    .reject    (reject),
    .fifo_full (fifo_full),
`ifdef COIN_COUNT_EN
    .fifo_empty(fifo_empty),
    .cnt1      (cnt1),
    .cnt2      (cnt2)
`else
    .fifo_empty(fifo_empty)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each sensor: synchronized samples arrive two edges late. A coin qualifies
  // when, after a release, the line has been high for Deb+1 consecutive
  // samples; a release needs Deb+1 consecutive low samples.
  int m_fifo [$];
  bit m_qual [2];
  bit m_rel  [2];
  bit m_lvl  [2];
  int m_run  [2];
  bit m_d1   [2];
  bit m_d2   [2];
  int m_coin;
  bit m_rej;
  int m_c1, m_c2;

  task automatic model_reset();
    m_fifo.delete();
    for (int i = 0; i < 2; i++) begin
      m_qual[i] = 0; m_rel[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_d1[i] = 0; m_d2[i] = 0;
    end
    m_coin = 0; m_rej = 0; m_c1 = 0; m_c2 = 0;
  endtask

  task automatic model_step(input bit r1, input bit r2, input bit h);
    int sz;
    bit p;
    bit s;
    bit nq [2];
    bit rw [2];
    sz = m_fifo.size();
    p  = (sz != 0) && !h;
    rw[0] = r1; rw[1] = r2;
    m_coin = 0;
    m_rej  = 0;
    if (p) begin
      m_coin = m_fifo.pop_front();
      if (m_coin == 1 && m_c1 < 65535) m_c1++;
      if (m_coin == 2 && m_c2 < 65535) m_c2++;
    end
    if (m_qual[0] && m_qual[1]) m_rej = 1;
    else if (m_qual[0] || m_qual[1]) begin
      if (sz < Depth || p) m_fifo.push_back(m_qual[0] ? 1 : 2);
      else m_rej = 1;
    end
    for (int i = 0; i < 2; i++) begin
      s = m_d2[i];
      nq[i] = 0;
      if (s == m_lvl[i]) m_run[i]++;
      else begin m_lvl[i] = s; m_run[i] = 1; end
      if (m_rel[i] && s && m_run[i] == Deb + 1) begin nq[i] = 1; m_rel[i] = 0; end
      else if (!m_rel[i] && !s && m_run[i] == Deb + 1) m_rel[i] = 1;
      m_d2[i] = m_d1[i];
      m_d1[i] = rw[i];
    end
    m_qual = nq;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step(coin1_raw, coin2_raw, hold);
  end

  always @(posedge clk) cyc++;

  // ---------------- per-cycle checker and event log ----------------
  int         ev_cyc  [$];
  logic [1:0] ev_code [$];
  int         n_rej;

  always @(negedge clk) begin
    if (!rst) begin
      check("coin_out", 32'(coin_out), m_coin);
      check("reject", 32'(reject), 32'(m_rej));
      check("fifo_full", 32'(fifo_full), 32'(m_fifo.size() == Depth));
      check("fifo_empty", 32'(fifo_empty), 32'(m_fifo.size() == 0));
`ifdef COIN_COUNT_EN
      check("cnt1", 32'(cnt1), m_c1);
      check("cnt2", 32'(cnt2), m_c2);
`endif
      if (coin_out != 2'b00) begin
        ev_cyc.push_back(cyc);
        ev_code.push_back(coin_out);
      end
      if (reject) n_rej++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit a, input bit b, input int n);
    coin1_raw = a;
    coin2_raw = b;
    cycles(n);
  endtask

  task automatic clear_logs();
    ev_cyc.delete();
    ev_code.delete();
    n_rej = 0;
  endtask

  function automatic int code_at(input int k);
    return (k < ev_code.size()) ? int'(ev_code[k]) : -1;
  endfunction

  function automatic int cyc_at(input int k);
    return (k < ev_cyc.size()) ? ev_cyc[k] : -100;
  endfunction

  typedef struct {
    int c1_len;
    int c2_len;
    int c2_dly;
    bit hold_on;
    int ones;
    int twos;
    int rej;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int t0;
    int n1;
    int n2;

    vecs[0] = '{c1_len: 12, c2_len: 0,  c2_dly: 0,  hold_on: 0, ones: 1, twos: 0, rej: 0};
    vecs[1] = '{c1_len: 0,  c2_len: 10, c2_dly: 0,  hold_on: 0, ones: 0, twos: 1, rej: 0};
    vecs[2] = '{c1_len: 4,  c2_len: 0,  c2_dly: 0,  hold_on: 0, ones: 0, twos: 0, rej: 0};
    vecs[3] = '{c1_len: 5,  c2_len: 0,  c2_dly: 0,  hold_on: 0, ones: 1, twos: 0, rej: 0};
    vecs[4] = '{c1_len: 10, c2_len: 10, c2_dly: 0,  hold_on: 0, ones: 0, twos: 0, rej: 1};
    vecs[5] = '{c1_len: 10, c2_len: 10, c2_dly: 20, hold_on: 1, ones: 1, twos: 1, rej: 0};
    vecs[6] = '{c1_len: 10, c2_len: 10, c2_dly: 2,  hold_on: 0, ones: 1, twos: 1, rej: 0};

    rst = 1'b1; coin1_raw = 1'b0; coin2_raw = 1'b0; hold = 1'b0;
    clear_logs();
    cycles(2);
    check("rst_coin_out", 32'(coin_out), 0);
    check("rst_reject", 32'(reject), 0);
    check("rst_full", 32'(fifo_full), 0);
    check("rst_empty", 32'(fifo_empty), 1);
    rst = 1'b0;
    cycles(12);

    // Clean coin 1: exact latency, single cycle, no reject.
    clear_logs();
    t0 = cyc + 1;
    drive(1, 0, 12);
    drive(0, 0, 20);
    check("lat_count", ev_code.size(), 1);
    check("lat_code", code_at(0), 1);
    check("lat_edges", cyc_at(0) - t0, Deb + 4);
    check("lat_reject", n_rej, 0);

    // Bouncy coin 2.
    clear_logs();
    drive(0, 1, 1); drive(0, 1, 1); drive(0, 0, 1); drive(0, 1, 1); drive(0, 0, 1);
    drive(0, 1, 10);
    drive(0, 0, 20);
    check("bounce_count", ev_code.size(), 1);
    check("bounce_code", code_at(0), 2);

    // Coins 1,2,1 queued under hold drain on consecutive cycles.
    clear_logs();
    hold = 1'b1;
    drive(1, 0, 10); drive(0, 0, 10);
    drive(0, 1, 10); drive(0, 0, 10);
    drive(1, 0, 10); drive(0, 0, 10);
    check("hold_none_yet", ev_code.size(), 0);
    hold = 1'b0;
    cycles(10);
    check("hold_count", ev_code.size(), 3);
    check("hold_code0", code_at(0), 1);
    check("hold_code1", code_at(1), 2);
    check("hold_code2", code_at(2), 1);
    check("hold_b2b", cyc_at(2) - cyc_at(0), 2);
    check("hold_reject", n_rej, 0);

    // Overfill: five coins into a four-entry queue.
    clear_logs();
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 10);
      drive(0, 0, 10);
      if (k == 2) check("full_after3", 32'(fifo_full), 0);
      if (k == 3) begin
        check("full_after4", 32'(fifo_full), 1);
        check("rej_after4", n_rej, 0);
      end
    end
    check("rej_after5", n_rej, 1);
    hold = 1'b0;
    cycles(10);
    check("drain_count", ev_code.size(), 4);
    check("drain_codes", (code_at(0) == 1 && code_at(1) == 1 && code_at(2) == 1
                          && code_at(3) == 1) ? 1 : 0, 1);
    check("drain_b2b", cyc_at(3) - cyc_at(0), 3);
    check("drain_empty", 32'(fifo_empty), 1);

    // Reset with coins queued and coin 1 held high.
    hold = 1'b1;
    drive(1, 0, 10); drive(0, 0, 10);
    drive(0, 1, 10); drive(0, 0, 10);
    coin1_raw = 1'b1;
    cycles(10);
    check("pre_rst_empty", 32'(fifo_empty), 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_coin_out", 32'(coin_out), 0);
    check("async_rst_reject", 32'(reject), 0);
    check("async_rst_full", 32'(fifo_full), 0);
    check("async_rst_empty", 32'(fifo_empty), 1);
    @(negedge clk);
    rst = 1'b0;
    hold = 1'b0;
    clear_logs();
    cycles(20);
    check("held_no_coin", ev_code.size(), 0);
    drive(0, 0, 10);
    drive(1, 0, 12);
    drive(0, 0, 12);
    check("rehit_count", ev_code.size(), 1);
    check("rehit_code", code_at(0), 1);

    // Scenario table.
    for (int v = 0; v < 7; v++) begin
      clear_logs();
      hold = vecs[v].hold_on;
      for (int t = 0; t < 40; t++) begin
        coin1_raw = (t < vecs[v].c1_len);
        coin2_raw = (t >= vecs[v].c2_dly) && (t < vecs[v].c2_dly + vecs[v].c2_len);
        cycles(1);
      end
      hold = 1'b0;
      cycles(15);
      n1 = 0;
      n2 = 0;
      foreach (ev_code[k]) begin
        if (ev_code[k] == 2'b01) n1++;
        if (ev_code[k] == 2'b10) n2++;
      end
      check($sformatf("vec%0d_ones", v), n1, vecs[v].ones);
      check($sformatf("vec%0d_twos", v), n2, vecs[v].twos);
      check($sformatf("vec%0d_rej", v), n_rej, vecs[v].rej);
    end

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) coin1_raw = ~coin1_raw;
      if ($urandom_range(0, 7) == 0) coin2_raw = ~coin2_raw;
      if ($urandom_range(0, 19) == 0) hold = ~hold;
      cycles(1);
    end
    coin1_raw = 1'b0;
    coin2_raw = 1'b0;
    hold = 1'b0;
    cycles(20);
    check("final_empty", 32'(fifo_empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
